ifu_fetch: RTL and testbench

Instruction fetch unit: owns the program counter, issues word reads to instruction memory and presents each fetched instruction to the decode stage on `instruction` / `Fetch_ready`. It sits directly upstream of the IDU and consumes redirects (taken branches, jumps) from the CU. One instruction is in flight at a time. Misaligned PCs and memory timeouts are reported as faults.

---
 rtl/ifu_pkg.sv | 26 ++
 rtl/ifu_fetch_timeout_ctr.sv | 29 ++
 rtl/ifu_fetch.sv | 170 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CTR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } ifu_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // Only word-aligned fetches are legal; there is no compressed-instruction support.
  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_fetch_timeout_ctr.sv
// Request wait-cycle counter; expired_c flags the last allowed REQ cycle without ack.
module ifu_timeout_ctr
  import ifu_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  logic [CTR_W-1:0] r_count;

  // Saturates so a stuck enable can never wrap back below the limit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CTR_W{1'b1}})) begin
      r_count <= r_count + CTR_W'(1);
    end
  end

  assign o_expired_c = i_en && (r_count == CTR_W'(LIMIT - 1));

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC ownership, one-at-a-time imem reads, hand-off to decode.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        IDU_ready,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  output logic [31:0] pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause
);

  ifu_state_e  r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic        r_ready, w_ready_nxt;
  logic        r_req, w_req_nxt;
  logic        r_fault, w_fault_nxt;
  logic [1:0]  r_cause, w_cause_nxt;
  logic        r_redir_pend, w_redir_pend_nxt;
  logic [31:0] r_redir_tgt, w_redir_tgt_nxt;
  logic        w_in_req;
  logic        w_expired;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;

  assign w_in_req = (r_state == ST_REQ);

  ifu_timeout_ctr #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timeout_ctr (
    .i_clk       (soc_clk),
    .i_rst_n     (reset),
    .i_clr       (!w_in_req),
    .i_en        (w_in_req),
    .o_expired_c (w_expired)
  );

  // A redirect in this cycle overrides an older latched one (last wins).
  assign w_redirect    = pc_load || r_redir_pend;
  assign w_redirect_pc = pc_load ? pc_target : r_redir_tgt;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_instr_nxt      = r_instr;
    w_ready_nxt      = 1'b0;
    w_req_nxt        = 1'b0;
    w_fault_nxt      = r_fault;
    w_cause_nxt      = r_cause;
    w_redir_pend_nxt = r_redir_pend;
    w_redir_tgt_nxt  = r_redir_tgt;

    case (r_state)
      ST_IDLE: begin
        w_redir_pend_nxt = 1'b0;
        // A redirect here takes effect now; the start decision waits for the new PC.
        if (pc_load) begin
          w_pc_nxt = pc_target;
        end else if (fetch_enable) begin
          if (is_misaligned(r_pc[1:0])) begin
            w_state_nxt = ST_FAULT;
            w_fault_nxt = 1'b1;
            w_cause_nxt = FC_MISALIGN;
          end else begin
            w_state_nxt = ST_REQ;
            w_req_nxt   = 1'b1;
          end
        end
      end

      ST_REQ: begin
        if (pc_load) begin
          w_redir_pend_nxt = 1'b1;
          w_redir_tgt_nxt  = pc_target;
        end
        if (imem_ack) begin
          if (w_redirect) begin
            w_pc_nxt         = w_redirect_pc;
            w_state_nxt      = ST_IDLE;
            w_redir_pend_nxt = 1'b0;
          end else begin
            w_instr_nxt = imem_rdata;
            w_state_nxt = ST_HOLD;
            w_ready_nxt = 1'b1;
          end
        end else if (w_expired) begin
          w_state_nxt      = ST_FAULT;
          w_fault_nxt      = 1'b1;
          w_cause_nxt      = FC_TIMEOUT;
          w_redir_pend_nxt = 1'b0;
        end else begin
          w_req_nxt = 1'b1;
        end
      end

      ST_HOLD: begin
        if (pc_load) begin
          w_redir_pend_nxt = 1'b1;
          w_redir_tgt_nxt  = pc_target;
        end
        if (IDU_ready) begin
          w_pc_nxt         = w_redirect ? w_redirect_pc : (r_pc + PC_STEP);
          w_state_nxt      = ST_IDLE;
          w_redir_pend_nxt = 1'b0;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end

      ST_FAULT: begin
        if (pc_load) begin
          w_pc_nxt    = pc_target;
          w_fault_nxt = 1'b0;
          w_cause_nxt = FC_NONE;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= INSTR_NOP;
      r_ready      <= 1'b0;
      r_req        <= 1'b0;
      r_fault      <= 1'b0;
      r_cause      <= FC_NONE;
      r_redir_pend <= 1'b0;
      r_redir_tgt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_instr      <= w_instr_nxt;
      r_ready      <= w_ready_nxt;
      r_req        <= w_req_nxt;
      r_fault      <= w_fault_nxt;
      r_cause      <= w_cause_nxt;
      r_redir_pend <= w_redir_pend_nxt;
      r_redir_tgt  <= w_redir_tgt_nxt;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign Fetch_ready = r_ready;
  assign pc          = r_pc;
  assign fetch_fault = r_fault;
  assign fault_cause = r_cause;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: memory responder, fetch scoreboard, directed sequences.
module tb_ifu_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        soc_clk;
  logic        reset;
  logic        fetch_enable;
  logic        IDU_ready;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instruction;
  logic        Fetch_ready;
  logic [31:0] pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  exp_t        exp_q[$];

  int unsigned mem_lat   = 0;
  bit          mem_mute  = 0;
  bit          force_ack = 0;

  ifu_fetch #(
    .RESET_PC    (32'h0000_0000),
    .MEM_TIMEOUT (15)
  ) dut (
    .soc_clk      (soc_clk),
    .reset        (reset),
    .fetch_enable (fetch_enable),
    .IDU_ready    (IDU_ready),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ack     (imem_ack),
    .instruction  (instruction),
    .Fetch_ready  (Fetch_ready),
    .pc           (pc),
    .fetch_fault  (fetch_fault),
    .fault_cause  (fault_cause)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A00_0013);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !Fetch_ready; i++) tick();
    check_eq("ready_wait", 32'(Fetch_ready), 32'd1);
  endtask

  // Holds the instruction for four cycles, then pulses IDU_ready.
  task automatic consume(input logic [31:0] exp_pc);
    repeat (3) tick();
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    check_eq("ready_fall", 32'(Fetch_ready), 32'd0);
    check_eq("pc_next", pc, exp_pc);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pc"},    pc,                     32'h0);
    check_eq({tag, "_instr"}, instruction,            32'h0000_0013);
    check_eq({tag, "_ready"}, 32'(Fetch_ready),       32'd0);
    check_eq({tag, "_req"},   32'(imem_req),          32'd0);
    check_eq({tag, "_fault"}, 32'(fetch_fault),       32'd0);
    check_eq({tag, "_cause"}, 32'(fault_cause),       32'd0);
  endtask

  // Memory model: acks after mem_lat waiting cycles unless muted.
  initial begin
    int unsigned wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      tick();
      if (force_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end else if (imem_req && !mem_mute) begin
        if (wait_cnt == mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wait_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard: every rising Fetch_ready must match the oldest expected fetch.
  initial begin
    logic prev_ready;
    exp_t e;
    prev_ready = 1'b0;
    forever begin
      tick();
      if (Fetch_ready && !prev_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected", pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_pc", pc, e.pc);
          check_eq("sb_instr", instruction, e.instr);
        end
      end
      prev_ready = Fetch_ready;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    fetch_enable = 1'b0;
    IDU_ready    = 1'b0;
    pc_load      = 1'b0;
    pc_target    = '0;
    repeat (3) tick();
    check_reset_vals("rst");

    // Best case fetch from RESET_PC.
    reset = 1'b1;
    tick();
    push_exp(32'h0);
    fetch_enable = 1'b1;
    tick();
    check_eq("c1_req", 32'(imem_req), 32'd1);
    check_eq("c1_addr", imem_addr, 32'h0);
    tick();
    check_eq("c2_ready", 32'(Fetch_ready), 32'd1);
    check_eq("c2_instr", instruction, 32'h0050_0093);
    consume(32'h4);
    push_exp(32'h4);
    tick();
    check_eq("seq_req", 32'(imem_req), 32'd1);
    check_eq("seq_addr", imem_addr, 32'h4);
    wait_ready();

    // Redirect in HOLD one cycle before consumption.
    repeat (2) tick();
    pc_load   = 1'b1;
    pc_target = 32'h100;
    tick();
    pc_load   = 1'b0;
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    check_eq("hold_redir_pc", pc, 32'h100);
    push_exp(32'h100);
    tick();
    check_eq("hold_redir_addr", imem_addr, 32'h100);
    wait_ready();

    // Redirect in REQ: late ack is discarded.
    mem_lat = 3;
    consume(32'h104);
    tick();
    check_eq("req_redir_req", 32'(imem_req), 32'd1);
    pc_load   = 1'b1;
    pc_target = 32'h300;
    tick();
    pc_load = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && pc != 32'h300; i++) begin
        seen |= Fetch_ready;
        tick();
      end
      seen |= Fetch_ready;
      check_eq("req_redir_pc", pc, 32'h300);
      check_eq("req_redir_noready", 32'(seen), 32'd0);
      check_eq("req_redir_instr", instruction, mem_word(32'h100));
    end
    mem_lat = 0;
    push_exp(32'h300);
    wait_ready();

    // Timeout after 15 REQ cycles without ack.
    mem_mute = 1'b1;
    consume(32'h304);
    tick();
    check_eq("to_req1", 32'(imem_req), 32'd1);
    repeat (14) tick();
    check_eq("to_req15_fault", 32'(fetch_fault), 32'd0);
    check_eq("to_req15_req", 32'(imem_req), 32'd1);
    tick();
    check_eq("to_fault", 32'(fetch_fault), 32'd1);
    check_eq("to_cause", 32'(fault_cause), 32'd2);
    check_eq("to_req_drop", 32'(imem_req), 32'd0);
    pc_load   = 1'b1;
    pc_target = 32'h200;
    mem_mute  = 1'b0;
    tick();
    pc_load = 1'b0;
    check_eq("to_clr_fault", 32'(fetch_fault), 32'd0);
    check_eq("to_clr_cause", 32'(fault_cause), 32'd0);
    check_eq("to_clr_pc", pc, 32'h200);
    push_exp(32'h200);
    wait_ready();

    // Misaligned redirect in IDLE.
    fetch_enable = 1'b0;
    consume(32'h204);
    pc_load   = 1'b1;
    pc_target = 32'h102;
    tick();
    pc_load = 1'b0;
    check_eq("mis_pc", pc, 32'h102);
    fetch_enable = 1'b1;
    tick();
    check_eq("mis_fault", 32'(fetch_fault), 32'd1);
    check_eq("mis_cause", 32'(fault_cause), 32'd1);
    check_eq("mis_req", 32'(imem_req), 32'd0);
    repeat (3) tick();
    check_eq("mis_req_hold", 32'(imem_req), 32'd0);
    check_eq("mis_fault_hold", 32'(fetch_fault), 32'd1);

    // PC wrap from the top word.
    pc_load   = 1'b1;
    pc_target = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC);
    tick();
    pc_load = 1'b0;
    check_eq("wrap_fault_clr", 32'(fetch_fault), 32'd0);
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
    wait_ready();
    consume(32'h0);
    push_exp(32'h0);
    wait_ready();
    consume(32'h4);

    // Reset mid-REQ, then a late ack in IDLE.
    mem_mute = 1'b1;
    tick();
    check_eq("mrst_req", 32'(imem_req), 32'd1);
    check_eq("mrst_addr", imem_addr, 32'h4);
    tick();
    reset        = 1'b0;
    fetch_enable = 1'b0;
    tick();
    check_reset_vals("mrst");
    reset     = 1'b1;
    force_ack = 1'b1;
    repeat (2) tick();
    check_eq("late_ack_req", 32'(imem_req), 32'd0);
    check_eq("late_ack_ready", 32'(Fetch_ready), 32'd0);
    check_eq("late_ack_instr", instruction, 32'h0000_0013);
    check_eq("late_ack_pc", pc, 32'h0);
    force_ack = 1'b0;
    mem_mute  = 1'b0;
    push_exp(32'h0);
    fetch_enable = 1'b1;
    wait_ready();
    consume(32'h4);

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
